flash_reader: RTL and testbench

SPI NOR flash read responder that serves the CPU's byte-fetch handshake (`enableFlash` / `flashReadAddr` / `flashDataReady` / `flashByteRead`).

- On each request it issues a standard READ (0x03) command to the external flash.
- It shifts in one byte and returns it to the CPU.
- It sits between the CPU core and the board's SPI flash pins.
- It owns the flash power-up delay, so the CPU can raise requests immediately after reset.

---
 rtl/flash_reader.sv | 143 ++++++++++++++
 tb/tb_flash_reader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_reader.sv
// SPI NOR flash byte reader: one READ (0x03) command per CPU request, mode 0, SCLK = clk/2.
// Holds off flash access for STARTUP_CYCLES after reset while leaving a pending request queued.
module flash_reader #(
    parameter logic [23:0] BASE_ADDR      = 24'h000000,
    parameter int unsigned STARTUP_CYCLES = 10000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] flashReadAddr,
    input  logic        enableFlash,
    output logic [7:0]  flashByteRead,
    output logic        flashDataReady,
    output logic        flashClk,
    output logic        flashCs,
    output logic        flashMosi,
    input  logic        flashMiso
);

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StSend,
        StRecv,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] init_cnt_q, init_cnt_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [31:0] sh_q, sh_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  byte_q, byte_d;
    logic        ready_q, ready_d;
    logic        cs_q, cs_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic [23:0] addr24;

    assign addr24 = BASE_ADDR + {13'b0, flashReadAddr};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
            cnt_q      <= '0;
            sh_q       <= '0;
            rx_q       <= '0;
            byte_q     <= '0;
            ready_q    <= 1'b1;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            rx_q       <= rx_d;
            byte_q     <= byte_d;
            ready_q    <= ready_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
        end
    end

    // cnt_q counts clk edges since the accept edge; an even value means the next edge raises SCLK.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        rx_d       = rx_q;
        byte_d     = byte_q;
        ready_d    = ready_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;

        unique case (state_q)
            StInit: begin
                init_cnt_d = init_cnt_q + 32'd1;
                if (init_cnt_q + 32'd1 >= STARTUP_CYCLES) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (enableFlash) begin
                    sh_d    = {8'h03, addr24};
                    mosi_d  = 1'b0;
                    cs_d    = 1'b0;
                    ready_d = 1'b0;
                    sclk_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                cnt_d = cnt_q + 7'd1;
                if (!cnt_q[0]) begin
                    sclk_d = 1'b1;
                end else begin
                    sclk_d = 1'b0;
                    if (cnt_q == 7'd63) begin
                        mosi_d  = 1'b0;
                        state_d = StRecv;
                    end else begin
                        sh_d   = {sh_q[30:0], 1'b0};
                        mosi_d = sh_q[30];
                    end
                end
            end
            StRecv: begin
                cnt_d = cnt_q + 7'd1;
                if (!cnt_q[0]) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[6:0], flashMiso};
                end else begin
                    sclk_d = 1'b0;
                    if (cnt_q == 7'd79) begin
                        cs_d    = 1'b1;
                        byte_d  = rx_q;
                        ready_d = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (!enableFlash) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StInit;
        endcase
    end

    assign flashByteRead  = byte_q;
    assign flashDataReady = ready_q;
    assign flashCs        = cs_q;
    assign flashClk       = sclk_q;
    assign flashMosi      = mosi_q;

endmodule

// File: tb/tb_flash_reader.sv
// Bench for flash_reader: behavioural SPI flash model plus a scoreboard of expected reads.
module tb_flash_reader;

    localparam int unsigned S = 20;
    localparam logic [23:0] BASE = 24'hFFFFFE;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] flashReadAddr = '0;
    logic        enableFlash = 1'b0;
    logic [7:0]  flashByteRead;
    logic        flashDataReady;
    logic        flashClk;
    logic        flashCs;
    logic        flashMosi;
    logic        flashMiso = 1'b0;

    flash_reader #(
        .BASE_ADDR      (BASE),
        .STARTUP_CYCLES (S)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flashReadAddr  (flashReadAddr),
        .enableFlash    (enableFlash),
        .flashByteRead  (flashByteRead),
        .flashDataReady (flashDataReady),
        .flashClk       (flashClk),
        .flashCs        (flashCs),
        .flashMosi      (flashMosi),
        .flashMiso      (flashMiso)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Flash contents: a few fixed bytes, everything else addr[7:0]^0x5A.
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h000000: return 8'h11;
            24'h000001: return 8'h22;
            24'h000002: return 8'h33;
            24'h000005: return 8'hA5;
            default:    return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // SPI mode-0 flash model
    int          bits = 0;
    int          rises = 0;
    int          last_rises = 0;
    int          windows = 0;
    logic        cs_prev = 1'b1;
    logic [31:0] cmd_sh = '0;

    always @(posedge flashCs or negedge flashCs or posedge flashClk) begin
        if (flashCs !== cs_prev) begin
            if (!flashCs) begin
                bits = 0;
                rises = 0;
                windows++;
            end else begin
                last_rises = rises;
            end
            cs_prev = flashCs;
        end else if (flashClk && !flashCs) begin
            rises++;
            if (bits < 32) cmd_sh = {cmd_sh[30:0], flashMosi};
            bits++;
        end
    end

    always @(negedge flashClk) begin
        if (!flashCs && bits >= 32 && bits < 40) begin
            flashMiso <= mem_byte(cmd_sh[23:0])[39 - bits];
        end
    end

    // Scoreboard
    typedef struct {
        logic [31:0] cmd;
        logic [7:0]  data;
    } exp_t;
    exp_t exp_q[$];

    int   low_cnt = 0;
    logic prev_ready = 1'b1;

    always @(negedge clk) begin
        if (reset) begin
            low_cnt = 0;
            prev_ready = 1'b1;
        end else begin
            if (!flashDataReady) begin
                low_cnt++;
            end else if (!prev_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_read", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("read_byte", {24'b0, flashByteRead}, {24'b0, e.data});
                    check("mosi_cmd_addr", cmd_sh, e.cmd);
                    check("sclk_rises", last_rises, 40);
                    check("ready_low_cycles", low_cnt, 80);
                    check("cs_high_after", {31'b0, flashCs}, 32'd1);
                end
                low_cnt = 0;
            end
            prev_ready = flashDataReady;
        end
    end

    task automatic push(input logic [23:0] a24, input logic [7:0] d);
        exp_t e;
        e.cmd = {8'h03, a24};
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready(input logic lvl, input int bound, input string name);
        int n = 0;
        while (flashDataReady !== lvl && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'b0, flashDataReady}, {31'b0, lvl});
    endtask

    task automatic cpu_read(input logic [10:0] a, output logic [7:0] got);
        @(negedge clk);
        flashReadAddr = a;
        enableFlash = 1'b1;
        wait_ready(1'b0, 5, "ready_fall");
        wait_ready(1'b1, 100, "ready_rise");
        got = flashByteRead;
        enableFlash = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cs"}, {31'b0, flashCs}, 32'd1);
        check({tag, "_sclk"}, {31'b0, flashClk}, 32'd0);
        check({tag, "_ready"}, {31'b0, flashDataReady}, 32'd1);
        check({tag, "_byte"}, {24'b0, flashByteRead}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] got;
        int n;
        int cs_low_early;
        int w0;

        // Power-up hold: request pending from reset release, CPU addr 2 -> flash 0x000000
        #12;
        check_reset_vals("rst");
        check("rst_mosi", {31'b0, flashMosi}, 32'd0);
        @(negedge clk);
        push(24'h000000, 8'h11);
        reset = 1'b0;
        flashReadAddr = 11'd2;
        enableFlash = 1'b1;
        n = 0;
        cs_low_early = 0;
        while (flashDataReady === 1'b1 && n < S + 10) begin
            @(negedge clk);
            if (flashDataReady === 1'b1) begin
                n++;
                if (flashCs !== 1'b1) cs_low_early++;
            end
        end
        check("startup_hold_in_range", {31'b0, (n >= int'(S) && n <= int'(S) + 2)}, 32'd1);
        check("startup_cs_high", cs_low_early, 0);
        wait_ready(1'b1, 100, "powerup_ready_rise");
        check("powerup_byte", {24'b0, flashByteRead}, 32'h11);
        enableFlash = 1'b0;

        // Basic read: CPU 7 -> flash 0x000005
        push(24'h000005, 8'hA5);
        cpu_read(11'd7, got);
        check("basic_byte", {24'b0, got}, 32'hA5);

        // Wrap: CPU 3 -> 0x000001, CPU 0x7FF -> 0x0007FD
        push(24'h000001, 8'h22);
        cpu_read(11'd3, got);
        check("wrap_byte", {24'b0, got}, 32'h22);
        push(24'h0007FD, 8'hA7);
        cpu_read(11'h7FF, got);
        check("wrap_hi_byte", {24'b0, got}, 32'hA7);

        // CPU-style back-to-back: flash 0,1,2
        w0 = windows;
        push(24'h000000, 8'h11);
        cpu_read(11'd2, got);
        check("b2b_byte0", {24'b0, got}, 32'h11);
        push(24'h000001, 8'h22);
        cpu_read(11'd3, got);
        check("b2b_byte1", {24'b0, got}, 32'h22);
        push(24'h000002, 8'h33);
        cpu_read(11'd4, got);
        check("b2b_byte2", {24'b0, got}, 32'h33);
        check("b2b_windows", windows - w0, 3);

        // Held enable: no new transfer while enable stays high
        push(24'h000001, 8'h22);
        @(negedge clk);
        flashReadAddr = 11'd3;
        enableFlash = 1'b1;
        wait_ready(1'b0, 5, "held_ready_fall");
        wait_ready(1'b1, 100, "held_ready_rise");
        w0 = windows;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("held_byte_stable", {24'b0, flashByteRead}, 32'h22);
        end
        check("held_no_window", windows - w0, 0);
        enableFlash = 1'b0;
        repeat (4) @(negedge clk);
        check("held_released_no_window", windows - w0, 0);
        check("held_ready_high", {31'b0, flashDataReady}, 32'd1);

        // Reset at T0+30, request stays pending and completes after INIT
        push(24'h000005, 8'hA5);
        @(negedge clk);
        flashReadAddr = 11'd7;
        enableFlash = 1'b1;
        wait_ready(1'b0, 5, "midrst_ready_fall");
        repeat (30) @(posedge clk);
        #1 reset = 1'b1;
        #1 check_reset_vals("midrst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_ready(1'b0, S + 10, "midrst_restart");
        wait_ready(1'b1, 100, "midrst_ready_rise");
        check("midrst_byte", {24'b0, flashByteRead}, 32'hA5);
        enableFlash = 1'b0;

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
